sdr_tune_ctrl: RTL and testbench



---
 rtl/sdr_tune_ctrl_if.sv | 26 ++
 rtl/sdr_tune_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sdr_tune_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_tune_ctrl_if.sv
// Command and status bundle between the UART side, the tuning controller and
// the NCO/CIC chain. The master drives received bytes. The slave (the
// controller) drives the tuning outputs and the acknowledge stream.
interface sdr_tune_ctrl_if #(
  parameter int PHASE_W = 64,
  parameter int GAIN_W  = 8
);
  logic               rx_dv;
  logic [7:0]         rx_byte;
  logic [PHASE_W-1:0] phase_inc;
  logic [GAIN_W-1:0]  cic_gain;
  logic               cfg_update;
  logic               ack_dv;
  logic [7:0]         ack_byte;
  logic               busy;

  modport master (
    output rx_dv, rx_byte,
    input  phase_inc, cic_gain, cfg_update, ack_dv, ack_byte, busy
  );

  modport slave (
    input  rx_dv, rx_byte,
    output phase_inc, cic_gain, cfg_update, ack_dv, ack_byte, busy
  );
endinterface

// File: rtl/sdr_tune_ctrl.sv
// Tuning and gain command controller for the 1-bit SDR receiver.
// It decodes single-byte UART commands into NCO phase-increment and CIC gain
// updates, using saturating frequency steps. The "F" command starts a raw
// multi-byte phase load that is guarded by an inter-byte timeout. Every
// command produces an echo byte, or "?" on error, for the UART transmitter.
module sdr_tune_ctrl #(
  parameter int          PHASE_W     = 64,
  parameter int          GAIN_W      = 8,
  parameter int          GAIN_MAX    = 3,
  parameter logic [63:0] STEP_9K     = 64'h71b375868d170,
  parameter logic [63:0] STEP_1K     = 64'hca22980ba57e,
  parameter logic [63:0] STEP_100    = 64'h1436a8cdf6f3,
  parameter logic [63:0] PRESET_A    = 64'h4CF41F212D77318,
  parameter logic [63:0] PRESET_B    = 64'h1aa60f8b8911654,
  parameter logic [63:0] PRESET_F    = 64'h1dc38c076704516d,
  parameter logic [63:0] PRESET_G    = 64'h1d60d923295482c6,
  parameter int          TIMEOUT_CYC = 800000
) (
  input  logic              clk,
  input  logic              rst_n,
  sdr_tune_ctrl_if.slave    bus
);

  localparam int NBYTES = PHASE_W / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PHASE_W-1:0] ALL_ONES = '1;
  localparam logic [PHASE_W-1:0] S9K      = STEP_9K[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] S1K      = STEP_1K[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] S100     = STEP_100[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] PA       = PRESET_A[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] PB       = PRESET_B[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] PF       = PRESET_F[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] PG       = PRESET_G[PHASE_W-1:0];

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_GMAX  = 8'(8'h30 + GAIN_MAX);
  localparam logic [7:0] CH_ERR   = 8'h3F;
  localparam logic [7:0] CH_LOAD  = 8'h46;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_F     = 8'h66;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_M     = 8'h6D;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_O     = 8'h6F;
  localparam logic [7:0] CH_P     = 8'h70;
  localparam logic [7:0] CH_Q     = 8'h71;
  localparam logic [7:0] CH_R     = 8'h72;

  typedef enum logic [1:0] {IDLE, LOAD, ERR_ACK} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               cfg_q, cfg_d;
  logic               ack_dv_q, ack_dv_d;
  logic [7:0]         ack_byte_q, ack_byte_d;
  logic               busy_q, busy_d;
  logic [PHASE_W-1:0] shadow_q, shadow_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [PHASE_W-1:0] step_sel;
  logic [PHASE_W:0]   step_sum;
  logic [PHASE_W:0]   step_diff;
  logic [PHASE_W-1:0] shifted;
  logic               is_gain_digit;

  // Steps are done one bit wider so that the carry or borrow shows overflow.
  assign step_sum      = {1'b0, phase_q} + {1'b0, step_sel};
  assign step_diff     = {1'b0, phase_q} - {1'b0, step_sel};
  assign shifted       = (shadow_q << 8) | PHASE_W'(bus.rx_byte);
  assign is_gain_digit = (bus.rx_byte >= CH_0) && (bus.rx_byte <= CH_GMAX);

  // Pick the step magnitude for the current command byte (the sign comes from the command).
  always_comb begin
    step_sel = '0;
    case (bus.rx_byte)
      CH_M, CH_N: step_sel = S9K;
      CH_P, CH_O: step_sel = S100;
      CH_R, CH_Q: step_sel = S1K;
      default:    step_sel = '0;
    endcase
  end

  // Command decode, direct-load collection and timeout handling.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gain_d     = gain_q;
    cfg_d      = 1'b0;
    ack_dv_d   = 1'b0;
    ack_byte_d = ack_byte_q;
    shadow_d   = shadow_q;
    bcnt_d     = bcnt_q;
    tmo_d      = '0;

    case (state_q)
      LOAD: begin
        if (bus.rx_dv) begin
          shadow_d = shifted;
          if (bcnt_q == BCNT_W'(NBYTES - 1)) begin
            phase_d    = shifted;
            cfg_d      = 1'b1;
            ack_dv_d   = 1'b1;
            ack_byte_d = CH_LOAD;
            state_d    = IDLE;
            bcnt_d     = '0;
            shadow_d   = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          ack_dv_d   = 1'b1;
          ack_byte_d = CH_ERR;
          state_d    = ERR_ACK;
          bcnt_d     = '0;
          shadow_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        if (bus.rx_dv) begin
          ack_dv_d   = 1'b1;
          ack_byte_d = bus.rx_byte;
          if (is_gain_digit) begin
            gain_d = GAIN_W'(bus.rx_byte - CH_0);
            cfg_d  = 1'b1;
          end else begin
            case (bus.rx_byte)
              CH_A: begin phase_d = PA; cfg_d = 1'b1; end
              CH_B: begin phase_d = PB; cfg_d = 1'b1; end
              CH_F: begin phase_d = PF; cfg_d = 1'b1; end
              CH_G: begin phase_d = PG; cfg_d = 1'b1; end
              CH_M, CH_P, CH_R: begin
                phase_d = step_sum[PHASE_W] ? ALL_ONES : step_sum[PHASE_W-1:0];
                cfg_d   = 1'b1;
              end
              CH_N, CH_O, CH_Q: begin
                phase_d = step_diff[PHASE_W] ? '0 : step_diff[PHASE_W-1:0];
                cfg_d   = 1'b1;
              end
              CH_LOAD: begin
                state_d    = LOAD;
                ack_dv_d   = 1'b0;
                ack_byte_d = ack_byte_q;
                bcnt_d     = '0;
                shadow_d   = '0;
              end
              default: ack_byte_d = CH_ERR;
            endcase
          end
        end
      end
    endcase

    busy_d = (state_d == LOAD);
  end

  // Register the state and every output so that effects appear one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      gain_q     <= '0;
      cfg_q      <= 1'b0;
      ack_dv_q   <= 1'b0;
      ack_byte_q <= '0;
      busy_q     <= 1'b0;
      shadow_q   <= '0;
      bcnt_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gain_q     <= gain_d;
      cfg_q      <= cfg_d;
      ack_dv_q   <= ack_dv_d;
      ack_byte_q <= ack_byte_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.phase_inc  = phase_q;
  assign bus.cic_gain   = gain_q;
  assign bus.cfg_update = cfg_q;
  assign bus.ack_dv     = ack_dv_q;
  assign bus.ack_byte   = ack_byte_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Bench for sdr_tune_ctrl. It applies directed command sequences and then
// randomized command traffic. A per-cycle reference model of the command
// protocol predicts every output.
module tb_sdr_tune_ctrl;

  localparam int          TMO      = 100;
  localparam int          GMAX     = 3;
  localparam int          NBYTES   = 8;
  localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] STEP_9K  = 64'h71b375868d170;
  localparam logic [63:0] STEP_1K  = 64'hca22980ba57e;
  localparam logic [63:0] STEP_100 = 64'h1436a8cdf6f3;
  localparam logic [63:0] PRE_A    = 64'h4CF41F212D77318;
  localparam logic [63:0] PRE_B    = 64'h1aa60f8b8911654;
  localparam logic [63:0] PRE_F    = 64'h1dc38c076704516d;
  localparam logic [63:0] PRE_G    = 64'h1d60d923295482c6;

  logic clk;
  logic rst_n;

  sdr_tune_ctrl_if #(.PHASE_W(64), .GAIN_W(8)) bus ();

  sdr_tune_ctrl #(.PHASE_W(64), .GAIN_W(8), .GAIN_MAX(GMAX), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [63:0] m_phase;
  logic [7:0]  m_gain;
  bit          m_loading;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic        e_cfg;
  logic        e_ack_dv;
  logic [7:0]  e_ack_byte;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase   = '0;
    m_gain    = '0;
    m_loading = 0;
    m_bytes.delete();
    m_idle    = 0;
  endtask

  // One clock of the command protocol, in terms of the user-visible rules.
  task automatic modelStep(input logic dv, input logic [7:0] b);
    logic [63:0] v;
    e_cfg    = 1'b0;
    e_ack_dv = 1'b0;
    if (m_loading) begin
      if (dv) begin
        m_bytes.push_back(b);
        m_idle = 0;
        if (m_bytes.size() == NBYTES) begin
          v = '0;
          foreach (m_bytes[i]) v = v * 256 + 64'(m_bytes[i]);
          m_phase    = v;
          e_cfg      = 1'b1;
          e_ack_dv   = 1'b1;
          e_ack_byte = 8'h46;
          m_loading  = 0;
          m_bytes.delete();
        end
      end else if (m_idle == TMO) begin
        m_loading  = 0;
        m_bytes.delete();
        e_ack_dv   = 1'b1;
        e_ack_byte = 8'h3F;
      end else begin
        m_idle++;
      end
    end else if (dv) begin
      e_ack_dv   = 1'b1;
      e_ack_byte = b;
      if (b >= 8'h30 && int'(b) <= 8'h30 + GMAX) begin
        m_gain = b - 8'h30;
        e_cfg  = 1'b1;
      end else begin
        e_cfg = 1'b1;
        case (b)
          8'h61: m_phase = PRE_A;
          8'h62: m_phase = PRE_B;
          8'h66: m_phase = PRE_F;
          8'h67: m_phase = PRE_G;
          8'h6D: m_phase = (m_phase > ALL1 - STEP_9K)  ? ALL1 : m_phase + STEP_9K;
          8'h70: m_phase = (m_phase > ALL1 - STEP_100) ? ALL1 : m_phase + STEP_100;
          8'h72: m_phase = (m_phase > ALL1 - STEP_1K)  ? ALL1 : m_phase + STEP_1K;
          8'h6E: m_phase = (m_phase < STEP_9K)  ? 64'd0 : m_phase - STEP_9K;
          8'h6F: m_phase = (m_phase < STEP_100) ? 64'd0 : m_phase - STEP_100;
          8'h71: m_phase = (m_phase < STEP_1K)  ? 64'd0 : m_phase - STEP_1K;
          8'h46: begin
            m_loading = 1;
            m_idle    = 0;
            m_bytes.delete();
            e_ack_dv  = 1'b0;
            e_cfg     = 1'b0;
          end
          default: begin
            e_ack_byte = 8'h3F;
            e_cfg      = 1'b0;
          end
        endcase
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("phase_inc", bus.phase_inc, m_phase);
    checkOutput("cic_gain", 64'(bus.cic_gain), 64'(m_gain));
    checkOutput("cfg_update", 64'(bus.cfg_update), 64'(e_cfg));
    checkOutput("ack_dv", 64'(bus.ack_dv), 64'(e_ack_dv));
    if (e_ack_dv) checkOutput("ack_byte", 64'(bus.ack_byte), 64'(e_ack_byte));
    checkOutput("busy", 64'(bus.busy), 64'(m_loading));
  endtask

  // Drive one cycle of input, then check the outputs registered on that edge.
  task automatic applyStimulus(input logic dv, input logic [7:0] b);
    @(negedge clk);
    bus.rx_dv   = dv;
    bus.rx_byte = b;
    @(posedge clk);
    #1;
    modelStep(dv, b);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.rx_dv = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst_phase", bus.phase_inc, 64'd0);
    checkOutput("rst_gain", 64'(bus.cic_gain), 64'd0);
    checkOutput("rst_cfg", 64'(bus.cfg_update), 64'd0);
    checkOutput("rst_ack_dv", 64'(bus.ack_dv), 64'd0);
    checkOutput("rst_ack_byte", 64'(bus.ack_byte), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    modelStep(1'b0, 8'h00);
    compareAll();
  endtask

  task automatic loadPhase(input logic [63:0] val, input int max_gap);
    logic [63:0] tmp;
    tmp = val;
    applyStimulus(1'b1, 8'h46);
    for (int i = 0; i < NBYTES; i++) begin
      idleCycles($urandom_range(0, max_gap));
      applyStimulus(1'b1, tmp[63:56]);
      tmp = tmp << 8;
    end
  endtask

  string cmds = "0123479abfgmnopqrFxA?";

  initial begin
    logic [63:0] held;
    logic [7:0]  b;
    rst_n       = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    modelReset();
    e_cfg = 0; e_ack_dv = 0; e_ack_byte = 0;
    #2;
    checkOutput("init_phase", bus.phase_inc, 64'd0);
    checkOutput("init_busy", 64'(bus.busy), 64'd0);

    // Preset and upward step.
    doReset();
    applyStimulus(1'b1, 8'h61);
    checkOutput("preset_a", bus.phase_inc, 64'h4CF41F212D77318);
    checkOutput("ack_a", 64'(bus.ack_byte), 64'h61);
    applyStimulus(1'b1, 8'h6D);
    checkOutput("a_plus_9k", bus.phase_inc, 64'h4CF41F212D77318 + 64'h71b375868d170);

    // Saturation at both ends.
    doReset();
    applyStimulus(1'b1, 8'h6F);
    checkOutput("sat_low", bus.phase_inc, 64'd0);
    checkOutput("sat_low_cfg", 64'(bus.cfg_update), 64'd1);
    loadPhase(ALL1, 0);
    applyStimulus(1'b1, 8'h6D);
    checkOutput("sat_high", bus.phase_inc, ALL1);

    // Gain digits and unknown commands.
    applyStimulus(1'b1, 8'h32);
    applyStimulus(1'b1, 8'h37);
    checkOutput("gain_hold", 64'(bus.cic_gain), 64'd2);
    checkOutput("gain_err_ack", 64'(bus.ack_byte), 64'h3F);
    applyStimulus(1'b1, 8'h78);

    // Direct load with spaced bytes.
    loadPhase(64'h0123456789ABCDEF, 30);
    checkOutput("load_val", bus.phase_inc, 64'h0123456789ABCDEF);

    // Timeout after a partial load, then a preset.
    held = m_phase;
    applyStimulus(1'b1, 8'h46);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom));
    idleCycles(TMO + 1);
    checkOutput("tmo_ack", 64'(bus.ack_byte), 64'h3F);
    checkOutput("tmo_phase", bus.phase_inc, held);
    applyStimulus(1'b1, 8'h62);
    checkOutput("preset_b", bus.phase_inc, PRE_B);

    // A byte arriving exactly at the timeout boundary wins.
    applyStimulus(1'b1, 8'h46);
    idleCycles(TMO);
    applyStimulus(1'b1, 8'h11);
    for (int i = 1; i < NBYTES; i++) applyStimulus(1'b1, 8'(8'h11 * (i + 1)));
    // One cycle later the load is abandoned and the next byte is a command.
    applyStimulus(1'b1, 8'h46);
    idleCycles(TMO + 1);
    applyStimulus(1'b1, 8'h31);

    // Reset in the middle of a load.
    applyStimulus(1'b1, 8'h46);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h31);
    doReset();
    applyStimulus(1'b1, 8'h31);
    checkOutput("post_rst_gain", 64'(bus.cic_gain), 64'd1);

    // Repeated identical strobes are separate commands.
    applyStimulus(1'b1, 8'h72);
    applyStimulus(1'b1, 8'h72);
    checkOutput("double_r", bus.phase_inc, STEP_1K + STEP_1K);

    // Randomized command traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        loadPhase({$urandom, $urandom}, (($urandom_range(0, 9) == 0) ? TMO + 5 : 20));
      end else begin
        if ($urandom_range(0, 9) < 3) b = 8'($urandom);
        else b = cmds[$urandom_range(0, cmds.len() - 1)];
        applyStimulus(1'($urandom_range(0, 1)), b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
